// File: rtl/shallow_fifo_stream_reader.sv
// shallow_fifo_stream_reader: two-entry skid buffer turning a show-ahead FIFO into a valid/ready stream.
// Reads are issued from occupancy alone, so m_ready never reaches fifo_rd_en combinationally.
module shallow_fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  push, pop;
  assign fifo_rd_en = rst_n & ~fifo_empty & (state_q != TWO) & ~flush;
  assign m_valid    = state_q != EMPTY;
  assign push       = fifo_rd_en;
  assign pop        = m_valid & m_ready;
  assign m_data     = head_q;
  assign occupancy  = state_q;
  assign word_cnt   = cnt_q;
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q + CNT_WIDTH'(pop);
    case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        head_d  = fifo_rd_data;
      end
      ONE: if (push && pop) head_d = fifo_rd_data;
      else if (push) begin
        state_d = TWO;
        skid_d  = fifo_rd_data;
      end else if (pop) state_d = EMPTY;
      TWO: if (pop) begin
        state_d = ONE;
        head_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // a pop in the flush cycle is still counted above; only buffered words are dropped
    if (flush) state_d = EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/shallow_fifo_stream_reader.md
SHALLOW_FIFO_STREAM_READER -- requirements
Module: shallow_fifo_stream_reader

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO and stream data.
- REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of delivered-word counter.
- REQ-003 SHALL have port clk, input, 1, single clock for all logic.
- REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-005 SHALL have port fifo_empty, input, 1, empty flag from the upstream FIFO.
- REQ-006 SHALL have port fifo_rd_data, input, DATA_WIDTH, FIFO head word; combinational, valid whenever fifo_empty=0.
- REQ-007 SHALL have port fifo_rd_en, output, 1, FIFO pop strobe; head advances at the next clk edge.
- REQ-008 SHALL have port m_valid, output, 1, stream word available.
- REQ-009 SHALL have port m_ready, input, 1, downstream accepts word.
- REQ-010 SHALL have port m_data, output, DATA_WIDTH, stream word.
- REQ-011 SHALL have port flush, input, 1, synchronous discard of buffered words.
- REQ-012 SHALL have port occupancy, output, 2, number of words held internally (0..2).
- REQ-013 SHALL have port word_cnt, output, CNT_WIDTH, count of completed stream handshakes.

Function
- REQ-014 SHALL hold two registers: head (drives m_data) and skid; occupancy encodes state EMPTY=0, ONE=1, TWO=2.
- REQ-015 SHALL define push = fifo_rd_en and pop = m_valid & m_ready.
- REQ-016 SHALL drive fifo_rd_en = ~fifo_empty & (occupancy < 2) & ~flush; there SHALL be no combinational path from m_ready to fifo_rd_en.
- REQ-017 SHALL drive m_valid = (occupancy != 0), purely from registers.
- REQ-018 EMPTY: push -> ONE, head <= fifo_rd_data; otherwise stay in EMPTY.
- REQ-019 ONE: push&pop -> ONE, head <= fifo_rd_data; push only -> TWO, skid <= fifo_rd_data; pop only -> EMPTY; neither -> stay in ONE.
- REQ-020 TWO: pop -> ONE, head <= skid; no pop -> stay in TWO; push never occurs in TWO.
- REQ-021 SHALL keep m_data stable while m_valid=1 and m_ready=0.
- REQ-022 Latency: FIFO non-empty in cycle N with the block in EMPTY SHALL give m_valid=1 in cycle N+1, with m_data equal to the word present in cycle N.
- REQ-023 SHALL sustain one word per cycle with m_ready held at 1 and FIFO non-empty (steady state ONE).
- REQ-024 SHALL preserve FIFO order exactly, with no drop or duplication except on flush.
- REQ-025 flush=1 SHALL set occupancy to 0 at the next edge and suppress fifo_rd_en in that cycle.
- REQ-026 A pop coinciding with flush SHALL count as delivered.
- REQ-027 word_cnt SHALL increment by 1 on each pop, SHALL wrap modulo 2^CNT_WIDTH, and SHALL be unaffected by flush.
- REQ-028 Removing fifo_empty=1 during TWO or ONE SHALL only stop pushes; buffered words SHALL still drain.

Reset
- REQ-029 rst_n=0 SHALL asynchronously force occupancy=0, m_valid=0, word_cnt=0, head=0 and skid=0.
- REQ-030 During reset, fifo_rd_en SHALL be 0.
- REQ-031 Reset asserted mid-transfer SHALL discard buffered words; the first edge after release SHALL behave as EMPTY.

Verification
- REQ-032 Bench SHALL cover: reset, then FIFO holding 0x11,0x22,0x33 with m_ready=1 -> m_data 0x11,0x22,0x33 in consecutive cycles starting 1 cycle after, and word_cnt=3.
- REQ-033 Bench SHALL cover: m_ready=0 with FIFO holding 5 words -> exactly 2 fifo_rd_en pulses, occupancy=2, m_data held at the first word; then m_ready=1 -> remaining words in order with no gap.
- REQ-034 Bench SHALL cover: flush asserted at occupancy=2 with m_ready=1 -> occupancy=0 next cycle, word_cnt +1, no fifo_rd_en in the flush cycle.
- REQ-035 Bench SHALL cover: CNT_WIDTH=4 with 17 handshakes -> word_cnt=1.
- REQ-036 Bench SHALL cover: rst_n pulsed low at occupancy=2 -> m_valid=0 immediately, and the next FIFO word appears 1 cycle after release.
- REQ-037 Bench SHALL cover: random m_ready and fifo_empty for 10k cycles -> output sequence equals FIFO sequence, and fifo_rd_en is never 1 while fifo_empty=1.
